// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
// Shared definitions for the SPI-attached RAM stage: the 2-bit command codes
// carried in din[9:8] and the default memory geometry used by spi_ram_ctrl and
// spi_ram_mem.
package spi_ram_pkg;

  // Default geometry: one byte per location, full 8-bit address space.
  localparam int DEFAULT_MEM_DEPTH = 256;
  localparam int DEFAULT_ADDR_SIZE = 8;

  // Command field of each 10-bit word coming out of the SPI slave.
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem
// Synchronous single-port byte memory with a registered read port, written so
// that synthesis maps it onto block RAM. The read register has a synchronous
// reset so that the read data seen downstream starts at zero; the array itself
// is never cleared.
//
// Ports:
//   i_clk    in   1          clock, rising edge
//   i_rstN   in   1          synchronous active-low reset of the read register
//   i_wrEn   in   1          write i_wrData to mem[i_addr]
//   i_rdEn   in   1          load mem[i_addr] into the read register
//   i_addr   in   ADDR_SIZE  shared read/write address
//   i_wrData in   8          write data
//   o_rdData out  8          registered read data, holds between reads
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_rstN,
  input  logic                 i_wrEn,
  input  logic                 i_rdEn,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [7:0]           i_wrData,
  output logic [7:0]           o_rdData
);

  logic [7:0] r_mem [MEM_DEPTH];
  logic [7:0] r_rdData;

  // Array write. Kept in its own process without a reset so the tools see a
  // plain RAM write port.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_addr] <= i_wrData;
    end
  end

  // Output register of the RAM. It only changes on an enabled read, which is
  // what lets dout hold its value between successful reads.
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_rdData <= 8'h00;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_addr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
// Command decoder sitting behind the SPI slave. Each new word (rising edge of
// rx_valid) is decoded into an address load, a memory write or a memory read.
// Reads return a byte on dout with a one-cycle tx_valid strobe; data accesses
// issued before their address has ever been loaded pulse err instead.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   din      in   10  {command[1:0], payload[7:0]} from the SPI slave
//   rx_valid in   1   din valid, may stay high for several cycles per word
//   dout     out  8   read data, holds until the next successful read
//   tx_valid out  1   one-cycle strobe, dout carries fresh read data
//   err      out  1   one-cycle strobe, data access without a loaded address
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  logic                 r_rxValidD;
  logic [ADDR_SIZE-1:0] r_wrAddr;
  logic [ADDR_SIZE-1:0] r_rdAddr;
  logic                 r_wrAddrVld;
  logic                 r_rdAddrVld;
  logic                 r_txValid;
  logic                 r_err;

  logic                 w_accept;
  cmd_t                 w_cmd;
  logic                 w_memWe;
  logic                 w_memRe;
  logic [ADDR_SIZE-1:0] w_memAddr;
  logic                 w_errNext;
  logic [7:0]           w_rdData;

  // A word is taken only on the first cycle rx_valid is seen high, so a slave
  // that holds rx_valid for a whole frame still produces one operation. Reset
  // in the same cycle suppresses the accept so no write or strobe can slip out.
  assign w_accept = rx_valid & ~r_rxValidD & rst_n;
  assign w_cmd    = cmd_t'(din[9:8]);

  // Decode the accepted word into memory port controls. The memory has one
  // address port; only one word is accepted per cycle, so it is shared between
  // the write and read addresses.
  always_comb begin
    w_memWe   = 1'b0;
    w_memRe   = 1'b0;
    w_memAddr = r_wrAddr;
    w_errNext = 1'b0;
    if (w_accept) begin
      case (w_cmd)
        CMD_WR_DATA: begin
          if (r_wrAddrVld) begin
            w_memWe = 1'b1;
          end else begin
            w_errNext = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          w_memAddr = r_rdAddr;
          if (r_rdAddrVld) begin
            w_memRe = 1'b1;
          end else begin
            w_errNext = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Edge-detect register, address registers with their sticky valid flags,
  // and the registered output strobes. Address increments wrap naturally at
  // the register width, which is the intended modulo behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxValidD  <= 1'b0;
      r_wrAddr    <= '0;
      r_rdAddr    <= '0;
      r_wrAddrVld <= 1'b0;
      r_rdAddrVld <= 1'b0;
      r_txValid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rxValidD <= rx_valid;
      r_txValid  <= w_memRe;
      r_err      <= w_errNext;
      if (w_accept) begin
        case (w_cmd)
          CMD_WR_ADDR: begin
            r_wrAddr    <= din[ADDR_SIZE-1:0];
            r_wrAddrVld <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (r_wrAddrVld && AUTO_INC) begin
              r_wrAddr <= r_wrAddr + ADDR_SIZE'(1);
            end
          end
          CMD_RD_ADDR: begin
            r_rdAddr    <= din[ADDR_SIZE-1:0];
            r_rdAddrVld <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (r_rdAddrVld && AUTO_INC) begin
              r_rdAddr <= r_rdAddr + ADDR_SIZE'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .i_clk    (clk),
    .i_rstN   (rst_n),
    .i_wrEn   (w_memWe),
    .i_rdEn   (w_memRe),
    .i_addr   (w_memAddr),
    .i_wrData (din[7:0]),
    .o_rdData (w_rdData)
  );

  assign dout     = w_rdData;
  assign tx_valid = r_txValid;
  assign err      = r_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl
// Drives two copies of spi_ram_ctrl (AUTO_INC=0 and AUTO_INC=1) with the same
// word stream. A cycle-level reference model built from the command rules
// (plain arrays and integer address arithmetic) predicts dout/tx_valid/err of
// both copies every cycle; a table of directed words and a few hand-written
// sequences add fixed expectations for the interesting corners.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rxValid = 1'b0;
  logic [7:0] dout0, dout1;
  logic       tx0, tx1, err0, err1;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  spi_ram_ctrl #(.AUTO_INC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxValid),
    .dout(dout0), .tx_valid(tx0), .err(err0)
  );

  spi_ram_ctrl #(.AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxValid),
    .dout(dout1), .tx_valid(tx1), .err(err1)
  );

  int checks = 0;
  int passes = 0;

  // Reference model state, index 0 = no auto-increment, 1 = auto-increment.
  logic [7:0] mMem [2][DEPTH];
  int         mWrA [2];
  int         mRdA [2];
  bit         mWrV [2];
  bit         mRdV [2];
  logic [7:0] mDout [2];
  bit         mTx [2];
  bit         mErr [2];
  bit         mPrevRx;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] payload;
    int         hold;
    logic [7:0] expDout;
    logic       expTx;
    logic       expErr;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [7:0] memInit(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  // Advance the model by one clock edge using the inputs that were stable
  // before that edge.
  task automatic modelStep();
    bit acc;
    if (!rst_n) begin
      mPrevRx = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mWrA[k] = 0; mRdA[k] = 0; mWrV[k] = 0; mRdV[k] = 0;
        mDout[k] = 8'h00; mTx[k] = 0; mErr[k] = 0;
      end
    end else begin
      acc = rxValid && !mPrevRx;
      mPrevRx = rxValid;
      for (int k = 0; k < 2; k++) begin
        mTx[k] = 0;
        mErr[k] = 0;
        if (acc) begin
          case (din[9:8])
            2'd0: begin mWrA[k] = int'(din[7:0]); mWrV[k] = 1; end
            2'd1: begin
              if (mWrV[k]) begin
                mMem[k][mWrA[k]] = din[7:0];
                if (k == 1) mWrA[k] = (mWrA[k] + 1) % DEPTH;
              end else mErr[k] = 1;
            end
            2'd2: begin mRdA[k] = int'(din[7:0]); mRdV[k] = 1; end
            default: begin
              if (mRdV[k]) begin
                mDout[k] = mMem[k][mRdA[k]];
                mTx[k] = 1;
                if (k == 1) mRdA[k] = (mRdA[k] + 1) % DEPTH;
              end else mErr[k] = 1;
            end
          endcase
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("dout0", dout0, mDout[0]);
    checkVal("tx0", {7'd0, tx0}, {7'd0, mTx[0]});
    checkVal("err0", {7'd0, err0}, {7'd0, mErr[0]});
    checkVal("dout1", dout1, mDout[1]);
    checkVal("tx1", {7'd0, tx1}, {7'd0, mTx[1]});
    checkVal("err1", {7'd0, err1}, {7'd0, mErr[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic sendWord(input logic [1:0] cmd, input logic [7:0] pay, input int hold, input int gap);
    din = {cmd, pay};
    rxValid = 1'b1;
    repeat (hold) tick();
    rxValid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    din = {v.cmd, v.payload};
    rxValid = 1'b1;
    tick();
    checkVal($sformatf("vec%0d.dout0", idx), dout0, v.expDout);
    checkVal($sformatf("vec%0d.dout1", idx), dout1, v.expDout);
    checkVal($sformatf("vec%0d.tx", idx), {6'd0, tx1, tx0}, {6'd0, v.expTx, v.expTx});
    checkVal($sformatf("vec%0d.err", idx), {6'd0, err1, err0}, {6'd0, v.expErr, v.expErr});
    repeat (v.hold - 1) tick();
    rxValid = 1'b0;
    tick();
    tick();
  endtask

  // Main test sequence.
  initial begin
    logic [7:0] a0, a1, b0, b1;

    vecs[0]  = '{CMD_WR_DATA, 8'h77, 1,  8'h00, 1'b0, 1'b1};
    vecs[1]  = '{CMD_RD_DATA, 8'h00, 1,  8'h00, 1'b0, 1'b1};
    vecs[2]  = '{CMD_RD_ADDR, 8'h00, 1,  8'h00, 1'b0, 1'b0};
    vecs[3]  = '{CMD_RD_DATA, 8'h00, 1,  8'h5A, 1'b1, 1'b0};
    vecs[4]  = '{CMD_WR_ADDR, 8'h3C, 1,  8'h5A, 1'b0, 1'b0};
    vecs[5]  = '{CMD_WR_DATA, 8'hA5, 1,  8'h5A, 1'b0, 1'b0};
    vecs[6]  = '{CMD_RD_ADDR, 8'h3C, 1,  8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{CMD_RD_DATA, 8'h00, 1,  8'hA5, 1'b1, 1'b0};
    vecs[8]  = '{CMD_WR_ADDR, 8'h05, 1,  8'hA5, 1'b0, 1'b0};
    vecs[9]  = '{CMD_WR_DATA, 8'h11, 12, 8'hA5, 1'b0, 1'b0};
    vecs[10] = '{CMD_RD_ADDR, 8'h05, 1,  8'hA5, 1'b0, 1'b0};
    vecs[11] = '{CMD_RD_DATA, 8'h00, 1,  8'h11, 1'b1, 1'b0};

    $display("[TB] reset");
    rst_n = 1'b0;
    tick();
    tick();
    checkVal("rst.dout0", dout0, 8'h00);
    checkVal("rst.dout1", dout1, 8'h00);
    checkVal("rst.strobes", {4'd0, tx0, tx1, err0, err1}, 8'h00);
    rst_n = 1'b1;

    $display("[TB] preloading memory");
    for (int i = 0; i < DEPTH; i++) begin
      sendWord(CMD_WR_ADDR, 8'(i), 1, 1);
      sendWord(CMD_WR_DATA, memInit(i), 1, 1);
    end

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    $display("[TB] auto-increment wrap");
    sendWord(CMD_WR_ADDR, 8'hFF, 1, 2);
    sendWord(CMD_WR_DATA, 8'h01, 1, 2);
    sendWord(CMD_WR_DATA, 8'h02, 1, 2);
    sendWord(CMD_RD_ADDR, 8'hFF, 1, 2);
    sendWord(CMD_RD_DATA, 8'h00, 1, 2);
    a0 = dout0; a1 = dout1;
    sendWord(CMD_RD_DATA, 8'h00, 1, 2);
    b0 = dout0; b1 = dout1;
    checkVal("inc.rd1.dut1", a1, 8'h01);
    checkVal("inc.rd2.dut1", b1, 8'h02);
    checkVal("inc.rd1.dut0", a0, 8'h02);
    checkVal("inc.rd2.dut0", b0, 8'h02);
    sendWord(CMD_RD_ADDR, 8'h00, 1, 2);
    sendWord(CMD_RD_DATA, 8'h00, 1, 2);
    checkVal("inc.mem0.dut1", dout1, 8'h02);
    checkVal("inc.mem0.dut0", dout0, 8'h5A);

    $display("[TB] reset during write accept");
    sendWord(CMD_WR_ADDR, 8'h10, 1, 2);
    din = {CMD_WR_DATA, 8'h99};
    rxValid = 1'b1;
    rst_n = 1'b0;
    tick();
    checkVal("midrst.dout", dout0 | dout1, 8'h00);
    checkVal("midrst.strobes", {4'd0, tx0, tx1, err0, err1}, 8'h00);
    rst_n = 1'b1;
    tick();
    checkVal("postrst.err", {6'd0, err1, err0}, 8'h03);
    checkVal("postrst.tx", {6'd0, tx1, tx0}, 8'h00);
    rxValid = 1'b0;
    tick();
    tick();
    sendWord(CMD_RD_ADDR, 8'h10, 1, 2);
    sendWord(CMD_RD_DATA, 8'h00, 1, 2);
    checkVal("midrst.mem.dut0", dout0, 8'h4A);
    checkVal("midrst.mem.dut1", dout1, 8'h4A);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      sendWord(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
